// File: rtl/bnn_layer_ctrl.sv
// Byte-stream sequencer for the binary conv layer: loads kernel, threshold and image, settles, streams the output map.
// Optional weight reuse (skip kernel/threshold load) is enabled by defining BNN_CTRL_WEIGHT_REUSE_EN.

module bnn_byte_field #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_nxt;

  // Each bit knows its byte index statically, so a write touches only the addressed slice.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign q_nxt[i] = (we && idx == CNT_W'(i / 8)) ? data[i % 8] : q[i];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
endmodule

module bnn_layer_ctrl #(
  parameter  int IMG_WIDTH       = 30,
  parameter  int KERNEL_LEN      = 3,
  parameter  int SETTLE_CYCLES   = 2,
  localparam int IMG_IN_SIZE     = IMG_WIDTH * IMG_WIDTH,
  localparam int OUT_LEN         = IMG_WIDTH - KERNEL_LEN + 1,
  localparam int IMG_OUT_SIZE    = OUT_LEN * OUT_LEN,
  localparam int KERNEL_SIZE     = KERNEL_LEN * KERNEL_LEN,
  localparam int THRESHOLD_WIDTH = $clog2(KERNEL_SIZE + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
`ifdef BNN_CTRL_WEIGHT_REUSE_EN
  input  logic                       reuse_w,
`endif
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [KERNEL_SIZE-1:0]     kernel_buf,
  output logic [THRESHOLD_WIDTH-1:0] threshold,
  output logic [IMG_IN_SIZE-1:0]     img_buf,
  input  logic [IMG_OUT_SIZE-1:0]    layer_out
);
  localparam int K_BYTES = (KERNEL_SIZE + 7) / 8;
  localparam int I_BYTES = (IMG_IN_SIZE + 7) / 8;
  localparam int O_BYTES = (IMG_OUT_SIZE + 7) / 8;
  localparam int CNT_MAX = (I_BYTES > O_BYTES) ?
                           ((I_BYTES > SETTLE_CYCLES) ? I_BYTES : SETTLE_CYCLES) :
                           ((O_BYTES > SETTLE_CYCLES) ? O_BYTES : SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CAP_W   = O_BYTES * 8;

  typedef enum logic [2:0] {IDLE, LD_K, LD_T, LD_I, SETTLE, STREAM} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CAP_W-1:0]   cap;
  logic               in_fire, out_fire, skip_w;
  logic               k_we, i_we, t_we, cap_ld;

  assign in_ready  = (state == LD_K) || (state == LD_T) || (state == LD_I);
  assign out_valid = (state == STREAM);
  assign busy      = (state != IDLE);
  assign in_fire   = in_ready & in_valid;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? cap[7:0] : 8'h00;

`ifdef BNN_CTRL_WEIGHT_REUSE_EN
  assign skip_w = reuse_w;
`else
  assign skip_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = skip_w ? LD_I : LD_K;
        end
      LD_K:
        if (in_fire) begin
          if (cnt == CNT_W'(K_BYTES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = LD_T;
          end else cnt_nxt = cnt + 1'b1;
        end
      LD_T:
        if (in_fire) begin
          cnt_nxt   = '0;
          state_nxt = LD_I;
        end
      LD_I:
        if (in_fire) begin
          if (cnt == CNT_W'(I_BYTES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = SETTLE;
          end else cnt_nxt = cnt + 1'b1;
        end
      SETTLE:
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = STREAM;
        end else cnt_nxt = cnt + 1'b1;
      STREAM:
        if (out_fire) begin
          if (cnt == CNT_W'(O_BYTES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else cnt_nxt = cnt + 1'b1;
        end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign k_we   = in_fire && (state == LD_K);
  assign t_we   = in_fire && (state == LD_T);
  assign i_we   = in_fire && (state == LD_I);
  assign cap_ld = (state == SETTLE) && (cnt == CNT_W'(SETTLE_CYCLES - 1));

  bnn_byte_field #(.WIDTH(KERNEL_SIZE), .CNT_W(CNT_W)) u_kernel (
    .clk(clk), .rst_n(rst_n), .we(k_we), .idx(cnt), .data(in_data), .q(kernel_buf)
  );

  bnn_byte_field #(.WIDTH(IMG_IN_SIZE), .CNT_W(CNT_W)) u_img (
    .clk(clk), .rst_n(rst_n), .we(i_we), .idx(cnt), .data(in_data), .q(img_buf)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    threshold <= '0;
    else if (t_we) threshold <= in_data[THRESHOLD_WIDTH-1:0];

  // Capture is zero-padded to whole bytes and shifted down so the current byte is always cap[7:0].
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        cap <= '0;
    else if (cap_ld)   cap <= CAP_W'(layer_out);
    else if (out_fire) cap <= cap >> 8;
endmodule
